duty_cycle_meter: RTL and testbench

- Measures the period, high time and duty cycle of a slow clock-like input (`sig_in`, e.g. a generated clock or PWM), all in cycles of the system clock `clk`.
- This is the receive-side checker for the clock/waveform generators used in this design.
- It synchronises the input, times rising-to-rising periods and returns one result per completed period. An optional sequential divider converts the result to integer percent.

---
 rtl/duty_meter_pkg.sv | 15 +
 rtl/duty_div.sv | 79 +++++++
 rtl/duty_cycle_meter.sv | 172 +++++++++++++++++
 tb/tb_duty_cycle_meter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/duty_meter_pkg.sv
// Shared types and constants for the duty-cycle meter and its divider.
package duty_meter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StStuck
    } meter_state_e;

    localparam int unsigned DUTY_W    = 7;
    localparam int unsigned DIV_LAT   = 8;
    localparam int unsigned PCT_SCALE = 100;

endpackage

// File: rtl/duty_div.sv
// Sequential restoring divider: one load cycle, then one quotient bit per cycle, MSB first.
// The quotient is known to fit in DUTY_W bits, so only DUTY_W trial subtractions are needed.
module duty_div
    import duty_meter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [CNT_W+DUTY_W-1:0]   num_i,
    input  logic [CNT_W-1:0]          den_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [DUTY_W-1:0]         quot_o
);

    localparam int unsigned NUM_W    = CNT_W + DUTY_W;
    localparam int unsigned LAST_STEP = DIV_LAT - 2;

    logic              busy_q, busy_d;
    logic [2:0]        step_q, step_d;
    logic [NUM_W-1:0]  rem_q, rem_d;
    logic [NUM_W-1:0]  den_q, den_d;
    logic [DUTY_W-1:0] quot_q, quot_d;

    logic              ge;
    logic              last;
    logic [DUTY_W-1:0] quot_next;

    assign ge        = (rem_q >= den_q);
    assign last      = (step_q == 3'(LAST_STEP));
    assign quot_next = {quot_q[DUTY_W-2:0], ge};

    assign busy_o = busy_q;
    assign done_o = busy_q & last;
    // Final bit is folded in combinationally so the result is usable on the done cycle.
    assign quot_o = quot_next;

    always_comb begin
        busy_d = busy_q;
        step_d = step_q;
        rem_d  = rem_q;
        den_d  = den_q;
        quot_d = quot_q;
        if (start_i) begin
            busy_d = 1'b1;
            step_d = 3'd0;
            rem_d  = num_i;
            den_d  = NUM_W'(den_i) << (DUTY_W - 1);
            quot_d = '0;
        end else if (busy_q) begin
            rem_d  = ge ? (rem_q - den_q) : rem_q;
            den_d  = den_q >> 1;
            quot_d = quot_next;
            step_d = step_q + 3'd1;
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            step_q <= 3'd0;
            rem_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
        end else begin
            busy_q <= busy_d;
            step_q <= step_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            quot_q <= quot_d;
        end
    end

endmodule

// File: rtl/duty_cycle_meter.sv
// Period / high-time / duty-cycle meter for a slow asynchronous input.
// Define DUTY_METER_DIV_EN to add the percent divider and overrun reporting.
module duty_cycle_meter
    import duty_meter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig_in,
    output logic              meas_valid,
    output logic [CNT_W-1:0]  period_o,
    output logic [CNT_W-1:0]  ton_o,
    output logic [DUTY_W-1:0] duty_pct_o,
    output logic              overrun_o,
    output logic              stuck_o
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             s1_q, s2_q, s3_q;
    logic             rise, fall;
    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic             cap;

    assign rise    = s2_q & ~s3_q;
    assign fall    = ~s2_q & s3_q;
    assign stuck_o = (state_q == StStuck);

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        hi_d    = hi_q;
        cap     = 1'b0;
        case (state_q)
            StIdle, StStuck: begin
                if (rise) begin
                    state_d = StHigh;
                    per_d   = CntOne;
                    hi_d    = CntOne;
                end
            end
            StHigh: begin
                per_d = per_q + CntOne;
                // The fall cycle already counts as low.
                if (!fall) begin
                    hi_d = hi_q + CntOne;
                end
                if (per_q == CntMax - CntOne) begin
                    state_d = StStuck;
                end else if (fall) begin
                    state_d = StLow;
                end
            end
            StLow: begin
                if (rise) begin
                    cap     = 1'b1;
                    state_d = StHigh;
                    per_d   = CntOne;
                    hi_d    = CntOne;
                end else begin
                    per_d = per_q + CntOne;
                    if (per_q == CntMax - CntOne) begin
                        state_d = StStuck;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            state_q <= StIdle;
            per_q   <= '0;
            hi_q    <= '0;
        end else begin
            s1_q    <= sig_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            per_q   <= per_d;
            hi_q    <= hi_d;
        end
    end

    logic             meas_q;
    logic [CNT_W-1:0] period_q, ton_q;

    assign meas_valid = meas_q;
    assign period_o   = period_q;
    assign ton_o      = ton_q;

`ifdef DUTY_METER_DIV_EN
    localparam int unsigned NUM_W = CNT_W + DUTY_W;

    logic              div_start, div_busy, div_done;
    logic [DUTY_W-1:0] div_quot;
    logic [NUM_W-1:0]  num;
    logic [CNT_W-1:0]  pend_per_q, pend_ton_q;
    logic [DUTY_W-1:0] duty_q;
    logic              overrun_q;

    assign num       = NUM_W'(hi_q) * NUM_W'(PCT_SCALE);
    // A capture landing on the finishing cycle is still accepted.
    assign div_start = cap & (~div_busy | div_done);

    duty_div #(
        .CNT_W (CNT_W)
    ) u_duty_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .num_i   (num),
        .den_i   (per_q),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quot_o  (div_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_per_q <= '0;
            pend_ton_q <= '0;
            meas_q     <= 1'b0;
            period_q   <= '0;
            ton_q      <= '0;
            duty_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            meas_q    <= div_done;
            overrun_q <= cap & ~div_start;
            if (div_done) begin
                period_q <= pend_per_q;
                ton_q    <= pend_ton_q;
                duty_q   <= div_quot;
            end
            if (div_start) begin
                pend_per_q <= per_q;
                pend_ton_q <= hi_q;
            end
        end
    end

    assign duty_pct_o = duty_q;
    assign overrun_o  = overrun_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            meas_q   <= 1'b0;
            period_q <= '0;
            ton_q    <= '0;
        end else begin
            meas_q <= cap;
            if (cap) begin
                period_q <= per_q;
                ton_q    <= hi_q;
            end
        end
    end

    assign duty_pct_o = '0;
    assign overrun_o  = 1'b0;
`endif

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Randomised and directed bench for duty_cycle_meter against an event-level model.
module tb_duty_cycle_meter;

    localparam int CW   = 6;
    localparam int MAXC = (1 << CW) - 1;
`ifdef DUTY_METER_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sig_in = 1'b0;
    logic          meas_valid;
    logic [CW-1:0] period_o, ton_o;
    logic [6:0]    duty_pct_o;
    logic          overrun_o, stuck_o;

    always #5 clk = ~clk;

    duty_cycle_meter #(
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .meas_valid (meas_valid),
        .period_o   (period_o),
        .ton_o      (ton_o),
        .duty_pct_o (duty_pct_o),
        .overrun_o  (overrun_o),
        .stuck_o    (stuck_o)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: track edge times of the synchronised input and derive results from them.
    bit check_en = 1'b0;
    int cyc = 0;
    bit d1, d2, d3, rise_m, fall_m;
    bit have_start, fall_seen, mstuck;
    int start_c, fall_c, c;
    bit exp_mv, exp_ov, exp_stuck;
    int exp_per, exp_ton, exp_duty;
    bit pend;
    int pend_due, pend_per, pend_ton, done_edge;

    always @(posedge clk) begin
        cyc++;
        exp_mv = 1'b0;
        exp_ov = 1'b0;
        if (rst) begin
            d1 = 0; d2 = 0; d3 = 0;
            have_start = 0; fall_seen = 0; mstuck = 0;
            exp_per = 0; exp_ton = 0; exp_duty = 0; exp_stuck = 0;
            pend = 0; done_edge = 0;
            check_en = 1'b1;
        end else begin
            rise_m = d2 & ~d3;
            fall_m = ~d2 & d3;
            c = cyc - 1;
            if (pend && pend_due == cyc) begin
                exp_mv = 1'b1;
                exp_per = pend_per;
                exp_ton = pend_ton;
                exp_duty = pend_ton * 100 / pend_per;
                pend = 1'b0;
            end
            if (rise_m) begin
                if (have_start && !mstuck) begin
                    if (DivEn) begin
                        if (cyc >= done_edge) begin
                            pend = 1'b1;
                            pend_due = cyc + 7;
                            pend_per = c - start_c;
                            pend_ton = fall_c - start_c;
                            done_edge = cyc + 7;
                        end else begin
                            exp_ov = 1'b1;
                        end
                    end else begin
                        exp_mv = 1'b1;
                        exp_per = c - start_c;
                        exp_ton = fall_c - start_c;
                    end
                end
                start_c = c; have_start = 1; fall_seen = 0; mstuck = 0;
            end else if (have_start && !mstuck) begin
                if (fall_m && !fall_seen) begin
                    fall_c = c;
                    fall_seen = 1;
                end
                if (c - start_c + 1 == MAXC) mstuck = 1;
            end
            exp_stuck = mstuck;
            d3 = d2; d2 = d1; d1 = sig_in;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("meas_valid", 32'(meas_valid), 32'(exp_mv));
            chk("period_o", 32'(period_o), exp_per);
            chk("ton_o", 32'(ton_o), exp_ton);
            chk("duty_pct_o", 32'(duty_pct_o), exp_duty);
            chk("overrun_o", 32'(overrun_o), 32'(exp_ov));
            chk("stuck_o", 32'(stuck_o), 32'(exp_stuck));
        end
    end

    int mv_cnt = 0, ov_cnt = 0;
    int last_per, last_ton, last_duty;
    always @(negedge clk) begin
        if (meas_valid) begin
            mv_cnt++;
            last_per = 32'(period_o);
            last_ton = 32'(ton_o);
            last_duty = 32'(duty_pct_o);
        end
        if (overrun_o) ov_cnt++;
    end

    task automatic wave(input int hi, input int lo, input int reps);
        for (int i = 0; i < reps; i++) begin
            sig_in = 1'b1;
            repeat (hi) @(negedge clk);
            sig_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic settle();
        repeat (14) @(negedge clk);
        #1;
    endtask

    int mv0, ov0;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_meas", 32'(meas_valid), 0);
        chk("reset_period", 32'(period_o), 0);
        chk("reset_stuck", 32'(stuck_o), 0);
        rst = 1'b0;

        // Basic 4/6 duty.
        mv0 = mv_cnt;
        wave(4, 6, 5);
        settle();
        chk("basic_count", mv_cnt - mv0, 4);
        chk("basic_period", last_per, 10);
        chk("basic_ton", last_ton, 4);
        chk("basic_duty", last_duty, DivEn ? 40 : 0);

        wave(16, 24, 3);
        settle();
        chk("p40_period", last_per, 40);
        chk("p40_ton", last_ton, 16);
        chk("p40_duty", last_duty, DivEn ? 40 : 0);

        wave(1, 2, 5);
        settle();
        chk("p3_period", last_per, 3);
        chk("p3_ton", last_ton, 1);
        chk("p3_duty", last_duty, DivEn ? 33 : 0);

        ov0 = ov_cnt;
        wave(1, 1, 10);
        settle();
        chk("overrun_seen", 32'(ov_cnt != ov0), 32'(DivEn));
        chk("p2_period", last_per, 2);
        chk("p2_ton", last_ton, 1);
        chk("p2_duty", last_duty, DivEn ? 50 : 0);

        // Stuck and recovery.
        wave(2, 80, 1);
        #1;
        chk("stuck_set", 32'(stuck_o), 1);
        mv0 = mv_cnt;
        wave(3, 5, 1);
        #1;
        chk("stuck_clear", 32'(stuck_o), 0);
        chk("stuck_no_result", mv_cnt - mv0, 0);
        wave(3, 5, 1);
        settle();
        chk("recover_count", mv_cnt - mv0, 1);
        chk("recover_period", last_per, 8);
        chk("recover_ton", last_ton, 3);
        chk("recover_duty", last_duty, DivEn ? 37 : 0);

        // Reset three cycles after a capture.
        wave(2, 3, 1);
        sig_in = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        mv0 = mv_cnt;
        sig_in = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_meas", 32'(meas_valid), 0);
        chk("midrst_period", 32'(period_o), 0);
        chk("midrst_ton", 32'(ton_o), 0);
        chk("midrst_duty", 32'(duty_pct_o), 0);
        @(negedge clk);
        rst = 1'b0;
        wave(3, 4, 2);
        settle();
        chk("postrst_count", mv_cnt - mv0, 1);
        chk("postrst_period", last_per, 7);
        chk("postrst_ton", last_ton, 3);
        chk("postrst_duty", last_duty, DivEn ? 42 : 0);

        // Random waveforms checked by the model every cycle.
        for (int i = 0; i < 60; i++) begin
            wave(int'($urandom_range(1, 20)), int'($urandom_range(1, 25)), 1);
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
